noc_src_arbiter: RTL

- Shares one NoC router injection port between NUM_SRC traffic sources (the per-node traffic generators in the bench BFMs).
- Uses round-robin arbitration with a burst lock: a granted source keeps the port for up to BURST consecutive flits.
- Registers the merged flit stream, keeps per-source accepted-flit counters, and aggregates the sources' done flags.

---
 rtl/noc_src_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/noc_src_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : noc_src_arbiter
// Purpose  : Round-robin, burst-locked merge of NUM_SRC flit sources onto one
//            NoC router injection port, with per-source flit counters.
// Revision : 1.0
// ============================================================================
module noc_src_arbiter #(
   parameter int WIDTH        = 32,
   parameter int N            = 16,
   parameter int N_ADDR_WIDTH = $clog2(N),
   parameter int NUM_SRC      = 4,
   parameter int SRC_W        = $clog2(NUM_SRC),
   parameter int BURST        = 4,
   parameter int CNT_W        = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_SRC*WIDTH-1:0]        src_data_in,
   input  logic [NUM_SRC*N_ADDR_WIDTH-1:0] src_dest_in,
   input  logic [NUM_SRC-1:0]              src_valid_in,
   output logic [NUM_SRC-1:0]              src_ready_out,
   input  logic [NUM_SRC-1:0]              src_done_in,
   output logic [WIDTH-1:0]                data_out,
   output logic [N_ADDR_WIDTH-1:0]         dest_out,
   output logic                            valid_out,
   input  logic                            ready_in,
   output logic [SRC_W-1:0]                grant_id,
   output logic                            busy,
   output logic                            all_done,
   output logic [NUM_SRC*CNT_W-1:0]        flit_cnt
);

   localparam int BW = $clog2(BURST + 1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t                  r_state;
   logic [SRC_W-1:0]        r_grant;
   logic [SRC_W-1:0]        r_last;
   logic [BW-1:0]           r_burst;
   logic                    r_valid;
   logic [WIDTH-1:0]        r_data;
   logic [N_ADDR_WIDTH-1:0] r_dest;
   logic                    r_all_done;
   logic [CNT_W-1:0]        r_cnt [NUM_SRC];

   logic [WIDTH-1:0]        w_data [NUM_SRC];
   logic [N_ADDR_WIDTH-1:0] w_dest [NUM_SRC];
   logic                    w_out_free;
   logic                    w_accept;
   logic                    w_found;
   logic [SRC_W-1:0]        w_pick;
   logic [SRC_W-1:0]        w_cand;

   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign w_data[gi] = src_data_in[gi*WIDTH +: WIDTH];
      assign w_dest[gi] = src_dest_in[gi*N_ADDR_WIDTH +: N_ADDR_WIDTH];
      assign flit_cnt[gi*CNT_W +: CNT_W] = r_cnt[gi];
   end

   // One-deep output register: a new flit may enter when it is empty or draining.
   assign w_out_free = !r_valid || ready_in;
   assign w_accept   = (r_state == S_GRANT) && w_out_free && src_valid_in[r_grant];

   always_comb begin
      src_ready_out = '0;
      if (r_state == S_GRANT && w_out_free)
         src_ready_out[r_grant] = 1'b1;
   end

   // Scan upward from the source after the last grant, wrapping once.
   always_comb begin
      w_found = 1'b0;
      w_pick  = r_last;
      w_cand  = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         w_cand = SRC_W'((int'(r_last) + k) % NUM_SRC);
         if (!w_found && src_valid_in[w_cand]) begin
            w_found = 1'b1;
            w_pick  = w_cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_grant    <= '0;
         r_last     <= SRC_W'(NUM_SRC - 1);
         r_burst    <= '0;
         r_valid    <= 1'b0;
         r_data     <= '0;
         r_dest     <= '0;
         r_all_done <= 1'b0;
         for (int i = 0; i < NUM_SRC; i++)
            r_cnt[i] <= '0;
      end else begin
         r_all_done <= &src_done_in;

         if (w_accept) begin
            r_data         <= w_data[r_grant];
            r_dest         <= w_dest[r_grant];
            r_valid        <= 1'b1;
            r_cnt[r_grant] <= r_cnt[r_grant] + 1'b1;
            r_burst        <= r_burst + 1'b1;
         end else if (ready_in) begin
            r_valid <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_grant <= w_pick;
                  r_last  <= w_pick;
                  r_burst <= '0;
                  r_state <= S_GRANT;
               end
            end
            S_GRANT: begin
               if (!src_valid_in[r_grant] || (w_accept && r_burst == BW'(BURST - 1)))
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign data_out  = r_data;
   assign dest_out  = r_dest;
   assign valid_out = r_valid;
   assign grant_id  = r_grant;
   assign busy      = (r_state == S_GRANT);
   assign all_done  = r_all_done;

endmodule
`default_nettype wire
